// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg : shared duty/step widths and duty-ramp FSM encoding (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package pwm_pkg;

   localparam int DUTY_W = 8;
   localparam int STEP_W = 4;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RAMP_UP   = 3'd1;
   localparam logic [2:0] ST_RAMP_DOWN = 3'd2;
   localparam logic [2:0] ST_HOLD      = 3'd3;
   localparam logic [2:0] ST_LIMIT     = 3'd4;
   localparam logic [2:0] ST_FAULT     = 3'd5;

endpackage

`default_nettype wire

// File: rtl/pwm_duty_ramp_if.sv
// ----------------------------------------------------------------------------
// pwm_duty_ramp_if : control/status bundle of one duty-ramp channel (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

interface pwm_duty_ramp_if #(
   parameter int WIDTH  = pwm_pkg::DUTY_W,
   parameter int STEP_W = pwm_pkg::STEP_W
);

   logic              enable;
   logic [WIDTH-1:0]  target;
   logic [STEP_W-1:0] step;
   logic              cycle;
   logic              v_limit;
   logic              i_limit;
   logic              fault_in;
   logic              clear_fault;
   logic [WIDTH-1:0]  pwm_o;
   logic              at_target;
   logic              limiting;
   logic              fault_latched;
   logic [2:0]        state_o;

   modport master (
      output enable, target, step, cycle, v_limit, i_limit, fault_in, clear_fault,
      input  pwm_o, at_target, limiting, fault_latched, state_o
   );

   modport slave (
      input  enable, target, step, cycle, v_limit, i_limit, fault_in, clear_fault,
      output pwm_o, at_target, limiting, fault_latched, state_o
   );

endinterface

`default_nettype wire

// File: rtl/pwm_duty_ramp_pad_sync.sv
// ----------------------------------------------------------------------------
// pad_sync : N-stage synchroniser for asynchronous pad inputs (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module pad_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pwm_duty_ramp.sv
// ----------------------------------------------------------------------------
// pwm_duty_ramp : soft-start / limit back-off / fault duty controller (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module pwm_duty_ramp #(
   parameter int WIDTH       = pwm_pkg::DUTY_W,
   parameter int STEP_W      = pwm_pkg::STEP_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic           wb_clk_i,
   input  logic           RESET_n,
   pwm_duty_ramp_if.slave bus
);

   import pwm_pkg::*;

   logic             v_lim_s;
   logic             i_lim_s;
   logic             fault_s;
   logic             lim_s;
   logic             cycle_d;
   logic             tick;

   logic [2:0]       state;
   logic [2:0]       state_nx;
   logic [WIDTH-1:0] duty;
   logic [WIDTH-1:0] duty_nx;
   logic             flt;
   logic             flt_nx;
   logic             at_tgt;
   logic             lim_flag;

   logic [WIDTH-1:0] step_eff;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   dif_ext;
   logic [WIDTH-1:0] up_val;
   logic [WIDTH-1:0] dn_val;
   logic [WIDTH-1:0] lim_val;

   pad_sync #(.STAGES(SYNC_STAGES)) u_sync_vlim (
      .clk   (wb_clk_i),
      .rst_n (RESET_n),
      .d     (bus.v_limit),
      .q     (v_lim_s)
   );

   pad_sync #(.STAGES(SYNC_STAGES)) u_sync_ilim (
      .clk   (wb_clk_i),
      .rst_n (RESET_n),
      .d     (bus.i_limit),
      .q     (i_lim_s)
   );

   pad_sync #(.STAGES(SYNC_STAGES)) u_sync_fault (
      .clk   (wb_clk_i),
      .rst_n (RESET_n),
      .d     (bus.fault_in),
      .q     (fault_s)
   );

   assign lim_s = v_lim_s | i_lim_s;

   always_ff @(posedge wb_clk_i or negedge RESET_n) begin
      if (!RESET_n) begin
         cycle_d <= 1'b0;
      end else begin
         cycle_d <= bus.cycle;
      end
   end

   assign tick = bus.cycle & ~cycle_d;

   // One extra bit of headroom so both over- and under-flow are visible before clamping
   assign step_eff = (bus.step == '0) ? WIDTH'(1) : WIDTH'(bus.step);
   assign sum_ext  = {1'b0, duty} + {1'b0, step_eff};
   assign dif_ext  = {1'b0, duty} - {1'b0, step_eff};
   assign up_val   = (sum_ext > {1'b0, bus.target}) ? bus.target : sum_ext[WIDTH-1:0];
   assign dn_val   = (dif_ext[WIDTH] || (dif_ext[WIDTH-1:0] < bus.target))
                     ? bus.target : dif_ext[WIDTH-1:0];
   assign lim_val  = dif_ext[WIDTH] ? '0 : dif_ext[WIDTH-1:0];

   always_comb begin
      state_nx = state;
      duty_nx  = duty;
      flt_nx   = flt;
      if (fault_s) begin
         state_nx = ST_FAULT;
         duty_nx  = '0;
         flt_nx   = 1'b1;
      end else if (state == ST_FAULT) begin
         if (bus.clear_fault) begin
            state_nx = ST_IDLE;
            flt_nx   = 1'b0;
         end
      end else if (!bus.enable) begin
         state_nx = ST_IDLE;
         duty_nx  = '0;
      end else if (tick) begin
         if (lim_s) begin
            state_nx = ST_LIMIT;
            duty_nx  = lim_val;
         end else if (duty < bus.target) begin
            state_nx = ST_RAMP_UP;
            duty_nx  = up_val;
         end else if (duty > bus.target) begin
            state_nx = ST_RAMP_DOWN;
            duty_nx  = dn_val;
         end else begin
            state_nx = ST_HOLD;
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge RESET_n) begin
      if (!RESET_n) begin
         state    <= ST_IDLE;
         duty     <= '0;
         flt      <= 1'b0;
         at_tgt   <= 1'b0;
         lim_flag <= 1'b0;
      end else begin
         state    <= state_nx;
         duty     <= duty_nx;
         flt      <= flt_nx;
         at_tgt   <= (state_nx == ST_HOLD) && (duty_nx == bus.target);
         lim_flag <= (state_nx == ST_LIMIT);
      end
   end

   assign bus.pwm_o         = duty;
   assign bus.at_target     = at_tgt;
   assign bus.limiting      = lim_flag;
   assign bus.fault_latched = flt;
   assign bus.state_o       = state;

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_ramp.sv
// ----------------------------------------------------------------------------
// tb_pwm_duty_ramp : directed + randomised bench against a behavioural model (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pwm_duty_ramp;

   localparam int SS = 2;

   logic clk;
   logic rst_n;

   int n_cmp;
   int n_err;

   // behavioural reference: plain integers, pad delay modelled with queues
   int m_duty;
   int m_state;
   int m_flt;
   int m_at;
   int m_lim;
   int m_cyc_d;
   int qv[$];
   int qi[$];
   int qf[$];

   pwm_duty_ramp_if #(.WIDTH(8), .STEP_W(4)) bus ();

   pwm_duty_ramp #(.WIDTH(8), .STEP_W(4), .SYNC_STAGES(SS)) dut (
      .wb_clk_i (clk),
      .RESET_n  (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   task automatic check_value(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  tag, obs, obs, exp, exp, $time);
      end
   endtask

   task automatic reset_model();
      m_duty  = 0;
      m_state = 0;
      m_flt   = 0;
      m_at    = 0;
      m_lim   = 0;
      m_cyc_d = 0;
      qv = {};
      qi = {};
      qf = {};
      for (int i = 0; i < SS; i++) begin
         qv.push_back(0);
         qi.push_back(0);
         qf.push_back(0);
      end
   endtask

   task automatic model_update();
      int vs, is_, fs, lim, tk, se, tg;
      if (!rst_n) begin
         reset_model();
         return;
      end
      vs  = qv.pop_front();  qv.push_back(int'(bus.v_limit));
      is_ = qi.pop_front();  qi.push_back(int'(bus.i_limit));
      fs  = qf.pop_front();  qf.push_back(int'(bus.fault_in));
      lim = vs | is_;
      tk  = (bus.cycle && m_cyc_d == 0) ? 1 : 0;
      m_cyc_d = int'(bus.cycle);
      se  = (bus.step == 0) ? 1 : int'(bus.step);
      tg  = int'(bus.target);
      if (fs != 0) begin
         m_state = 5; m_duty = 0; m_flt = 1;
      end else if (m_state == 5) begin
         if (bus.clear_fault) begin
            m_state = 0; m_flt = 0;
         end
      end else if (!bus.enable) begin
         m_state = 0; m_duty = 0;
      end else if (tk != 0) begin
         if (lim != 0) begin
            m_duty  = (m_duty - se < 0) ? 0 : m_duty - se;
            m_state = 4;
         end else if (m_duty < tg) begin
            m_duty  = (m_duty + se > tg) ? tg : m_duty + se;
            m_state = 1;
         end else if (m_duty > tg) begin
            m_duty  = (m_duty - se < tg) ? tg : m_duty - se;
            m_state = 2;
         end else begin
            m_state = 3;
         end
      end
      m_at  = (m_state == 3 && m_duty == tg) ? 1 : 0;
      m_lim = (m_state == 4) ? 1 : 0;
   endtask

   task automatic compare_model();
      check_value("mdl_pwm",   int'(bus.pwm_o),         m_duty);
      check_value("mdl_state", int'(bus.state_o),       m_state);
      check_value("mdl_flt",   int'(bus.fault_latched), m_flt);
      check_value("mdl_at",    int'(bus.at_target),     m_at);
      check_value("mdl_lim",   int'(bus.limiting),      m_lim);
   endtask

   task automatic step_clk();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_model();
   endtask

   task automatic run_period(input int lo, input int hi);
      bus.cycle = 1'b0;
      repeat (lo) step_clk();
      bus.cycle = 1'b1;
      repeat (hi) step_clk();
      bus.cycle = 1'b0;
   endtask

   task automatic ramp_until(input int val, input int max_periods);
      for (int k = 0; k < max_periods; k++) begin
         if (int'(bus.pwm_o) == val) break;
         run_period(12, 4);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.enable      = 1'b0;
      bus.target      = '0;
      bus.step        = '0;
      bus.cycle       = 1'b0;
      bus.v_limit     = 1'b0;
      bus.i_limit     = 1'b0;
      bus.fault_in    = 1'b0;
      bus.clear_fault = 1'b0;
      reset_model();
      repeat (3) step_clk();
      check_value("rst_pwm",   int'(bus.pwm_o), 0);
      check_value("rst_state", int'(bus.state_o), 0);
      check_value("rst_at",    int'(bus.at_target), 0);
      check_value("rst_lim",   int'(bus.limiting), 0);
      check_value("rst_flt",   int'(bus.fault_latched), 0);
      rst_n = 1'b1;

      // soft start 0 -> 0x40 in steps of 4
      bus.enable = 1'b1;
      bus.target = 8'h40;
      bus.step   = 4'd4;
      for (int k = 1; k <= 16; k++) begin
         run_period(12, 4);
         check_value("ss_pwm", int'(bus.pwm_o), 4 * k);
      end
      check_value("ss_state16", int'(bus.state_o), 1);
      run_period(12, 4);
      check_value("ss_hold", int'(bus.state_o), 3);
      check_value("ss_at",   int'(bus.at_target), 1);

      // saturation at the top and step=0 behaving as 1
      bus.target = 8'hF5;
      bus.step   = 4'hF;
      ramp_until(8'hF5, 20);
      check_value("sat_pre", int'(bus.pwm_o), 8'hF5);
      bus.target = 8'hFF;
      run_period(12, 4);
      check_value("sat_top", int'(bus.pwm_o), 8'hFF);
      bus.target = 8'h10;
      ramp_until(8'h10, 25);
      check_value("sat_down", int'(bus.pwm_o), 8'h10);
      bus.target = 8'h12;
      bus.step   = 4'd0;
      run_period(12, 4);
      check_value("step0_a", int'(bus.pwm_o), 8'h11);
      run_period(12, 4);
      check_value("step0_b", int'(bus.pwm_o), 8'h12);
      run_period(12, 4);
      check_value("step0_hold", int'(bus.at_target), 1);

      // limit back-off then recovery
      bus.target = 8'h80;
      bus.step   = 4'd8;
      ramp_until(8'h80, 25);
      check_value("lim_pre", int'(bus.pwm_o), 8'h80);
      bus.i_limit = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         run_period(12, 4);
         check_value("lim_pwm",  int'(bus.pwm_o), 8'h80 - 8 * k);
         check_value("lim_flag", int'(bus.limiting), 1);
         check_value("lim_st",   int'(bus.state_o), 4);
      end
      bus.i_limit = 1'b0;
      run_period(12, 4);
      check_value("lim_rel_pwm",  int'(bus.pwm_o), 8'h70);
      check_value("lim_rel_flag", int'(bus.limiting), 0);
      check_value("lim_rel_st",   int'(bus.state_o), 1);

      // fault latency, ignored clear, clear after release
      bus.target = 8'h60;
      ramp_until(8'h60, 10);
      check_value("flt_pre", int'(bus.pwm_o), 8'h60);
      bus.fault_in = 1'b1;
      repeat (SS) step_clk();
      check_value("flt_early", int'(bus.pwm_o), 8'h60);
      step_clk();
      check_value("flt_pwm",   int'(bus.pwm_o), 0);
      check_value("flt_latch", int'(bus.fault_latched), 1);
      check_value("flt_state", int'(bus.state_o), 5);
      bus.clear_fault = 1'b1;
      step_clk();
      bus.clear_fault = 1'b0;
      check_value("flt_clr_ign", int'(bus.state_o), 5);
      check_value("flt_clr_lat", int'(bus.fault_latched), 1);
      bus.fault_in = 1'b0;
      repeat (4) step_clk();
      bus.clear_fault = 1'b1;
      step_clk();
      bus.clear_fault = 1'b0;
      check_value("flt_clr_st",  int'(bus.state_o), 0);
      check_value("flt_clr_lat0", int'(bus.fault_latched), 0);
      run_period(12, 4);
      check_value("flt_restart", int'(bus.pwm_o), 8);

      // mid-ramp reversal and enable drop
      bus.target = 8'h40;
      ramp_until(8'h30, 10);
      check_value("rev_pre", int'(bus.pwm_o), 8'h30);
      bus.target = 8'h10;
      for (int k = 1; k <= 4; k++) begin
         run_period(12, 4);
         check_value("rev_pwm", int'(bus.pwm_o), 8'h30 - 8 * k);
      end
      bus.enable = 1'b0;
      step_clk();
      check_value("en_off_pwm", int'(bus.pwm_o), 0);
      check_value("en_off_st",  int'(bus.state_o), 0);

      // asynchronous reset between edges
      bus.enable = 1'b1;
      bus.target = 8'h80;
      repeat (3) run_period(12, 4);
      check_value("ar_pre", int'(bus.pwm_o), 8'h18);
      #2 rst_n = 1'b0;
      #1;
      check_value("ar_pwm",   int'(bus.pwm_o), 0);
      check_value("ar_state", int'(bus.state_o), 0);
      reset_model();
      repeat (3) step_clk();
      rst_n = 1'b1;
      repeat (10) step_clk();
      check_value("ar_quiet", int'(bus.pwm_o), 0);
      run_period(12, 4);
      check_value("ar_first", int'(bus.pwm_o), 8);

      // randomised traffic, checked every clock by the model
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 4) == 0) bus.target = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 4) == 0) bus.step   = 4'($urandom_range(0, 15));
         bus.v_limit  = ($urandom_range(0, 9) == 0);
         bus.i_limit  = ($urandom_range(0, 9) == 0);
         bus.fault_in = ($urandom_range(0, 40) == 0);
         bus.enable   = ($urandom_range(0, 25) != 0);
         if ($urandom_range(0, 3) == 0) begin
            bus.clear_fault = 1'b1;
            step_clk();
            bus.clear_fault = 1'b0;
         end
         run_period($urandom_range(1, 8), $urandom_range(1, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
